// File: rtl/dds_lut_scheduler.sv
// dds_lut_scheduler: time-multiplexes one shared quarter-wave sine LUT across N_CH DDS channels.
// Ports: clk/rst (async, active high); sample_tick starts a round over the ch_en snapshot;
// cfg_valid/cfg_ready/cfg_ch/cfg_data write per-channel FTWs (IDLE only); lut_phase/lut_sine
// talk to the LUT; out_valid/out_ch/out_data carry tagged samples; round_done, busy, overrun
// report round status. Optional macro DDS_PHASE_OFS_EN adds cfg_ofs_sel and per-channel
// phase offsets applied to lut_phase only.
module dds_lut_scheduler #(
  parameter int N_CH    = 4,
  parameter int CH_W    = 2,
  parameter int PHASE_W = 14,
  parameter int AMP_W   = 12
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               sample_tick,
  input  logic [N_CH-1:0]    ch_en,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [CH_W-1:0]    cfg_ch,
  input  logic [PHASE_W-1:0] cfg_data,
`ifdef DDS_PHASE_OFS_EN
  input  logic               cfg_ofs_sel,
`endif
  output logic [PHASE_W-1:0] lut_phase,
  input  logic [AMP_W-1:0]   lut_sine,
  output logic               out_valid,
  output logic [CH_W-1:0]    out_ch,
  output logic [AMP_W-1:0]   out_data,
  output logic               round_done,
  output logic               busy,
  output logic               overrun
);
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;
  state_t state_q, state_d;
  logic [N_CH-1:0] rem_q, rem_d;
  logic [PHASE_W-1:0] acc_q [N_CH];
  logic [PHASE_W-1:0] acc_d [N_CH];
  logic [PHASE_W-1:0] ftw_q [N_CH];
  logic [PHASE_W-1:0] ftw_d [N_CH];
`ifdef DDS_PHASE_OFS_EN
  logic [PHASE_W-1:0] ofs_q [N_CH];
  logic [PHASE_W-1:0] ofs_d [N_CH];
`endif
  logic [PHASE_W-1:0] lut_phase_q, lut_phase_d;
  logic cap_q, cap_d;
  logic [CH_W-1:0] cap_ch_q, cap_ch_d;
  logic out_valid_q, out_valid_d;
  logic [CH_W-1:0] out_ch_q, out_ch_d;
  logic [AMP_W-1:0] out_data_q, out_data_d;
  logic round_done_q, round_done_d;
  logic busy_q, busy_d;
  logic cfg_ready_q, cfg_ready_d;
  logic overrun_q, overrun_d;
  logic [CH_W-1:0] idx;
  logic cfg_wr;
  always_comb begin
    idx = '0;
    for (int i = N_CH - 1; i >= 0; i--) if (rem_q[i]) idx = CH_W'(i);
  end
  assign cfg_wr = cfg_valid && cfg_ready_q && (32'(cfg_ch) < N_CH);
  always_comb begin
    state_d      = state_q;
    rem_d        = rem_q;
    acc_d        = acc_q;
    ftw_d        = ftw_q;
`ifdef DDS_PHASE_OFS_EN
    ofs_d        = ofs_q;
`endif
    lut_phase_d  = lut_phase_q;
    cap_d        = 1'b0;
    cap_ch_d     = cap_ch_q;
    out_valid_d  = cap_q;
    out_ch_d     = cap_q ? cap_ch_q : out_ch_q;
    out_data_d   = cap_q ? lut_sine : out_data_q;
    round_done_d = 1'b0;
    overrun_d    = overrun_q | (sample_tick & busy_q);
`ifdef DDS_PHASE_OFS_EN
    if (cfg_wr && cfg_ofs_sel) ofs_d[cfg_ch] = cfg_data;
    if (cfg_wr && !cfg_ofs_sel) ftw_d[cfg_ch] = cfg_data;
`else
    if (cfg_wr) ftw_d[cfg_ch] = cfg_data;
`endif
    case (state_q)
      IDLE: if (sample_tick && !busy_q) begin
        rem_d   = ch_en;
        state_d = ISSUE;
      end
      ISSUE: begin
        if (rem_q != '0) begin
`ifdef DDS_PHASE_OFS_EN
          lut_phase_d = acc_q[idx] + ofs_q[idx];
`else
          lut_phase_d = acc_q[idx];
`endif
          acc_d[idx] = acc_q[idx] + ftw_q[idx];
          cap_d      = 1'b1;
          cap_ch_d   = idx;
          rem_d[idx] = 1'b0;
        end
        state_d = (rem_d == '0) ? DRAIN : ISSUE;
      end
      DRAIN: if (!cap_q) begin
        state_d      = IDLE;
        round_done_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    busy_d      = (state_d != IDLE) || round_done_d;
    cfg_ready_d = !busy_d;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      rem_q        <= '0;
      acc_q        <= '{default: '0};
      ftw_q        <= '{default: '0};
`ifdef DDS_PHASE_OFS_EN
      ofs_q        <= '{default: '0};
`endif
      lut_phase_q  <= '0;
      cap_q        <= 1'b0;
      cap_ch_q     <= '0;
      out_valid_q  <= 1'b0;
      out_ch_q     <= '0;
      out_data_q   <= '0;
      round_done_q <= 1'b0;
      busy_q       <= 1'b0;
      cfg_ready_q  <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      rem_q        <= rem_d;
      acc_q        <= acc_d;
      ftw_q        <= ftw_d;
`ifdef DDS_PHASE_OFS_EN
      ofs_q        <= ofs_d;
`endif
      lut_phase_q  <= lut_phase_d;
      cap_q        <= cap_d;
      cap_ch_q     <= cap_ch_d;
      out_valid_q  <= out_valid_d;
      out_ch_q     <= out_ch_d;
      out_data_q   <= out_data_d;
      round_done_q <= round_done_d;
      busy_q       <= busy_d;
      cfg_ready_q  <= cfg_ready_d;
      overrun_q    <= overrun_d;
    end
  end
  assign lut_phase  = lut_phase_q;
  assign out_valid  = out_valid_q;
  assign out_ch     = out_ch_q;
  assign out_data   = out_data_q;
  assign round_done = round_done_q;
  assign busy       = busy_q;
  assign cfg_ready  = cfg_ready_q;
  assign overrun    = overrun_q;
endmodule

// File: tb/tb_dds_lut_scheduler.sv
// tb_dds_lut_scheduler: randomized self-checking bench against a round-level reference model.
module tb_dds_lut_scheduler;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sample_tick = 1'b0;
  logic [3:0] ch_en = '0;
  logic cfg_valid = 1'b0;
  logic cfg_ready;
  logic [1:0] cfg_ch = '0;
  logic [13:0] cfg_data = '0;
  logic [13:0] lut_phase;
  logic [11:0] lut_sine;
  logic out_valid;
  logic [1:0] out_ch;
  logic [11:0] out_data;
  logic round_done, busy, overrun;
  int errors = 0;
  int checks = 0;
  logic [13:0] acc_m [4];
  logic [13:0] ftw_m [4];
  always #5 clk = ~clk;
  function automatic logic [11:0] sine_f(input logic [13:0] p);
    return p[13:2] ^ 12'h5A3;
  endfunction
  assign lut_sine = sine_f(lut_phase);
  dds_lut_scheduler dut (
    .clk(clk), .rst(rst), .sample_tick(sample_tick), .ch_en(ch_en),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_ch(cfg_ch), .cfg_data(cfg_data),
`ifdef DDS_PHASE_OFS_EN
    .cfg_ofs_sel(1'b0),
`endif
    .lut_phase(lut_phase), .lut_sine(lut_sine), .out_valid(out_valid), .out_ch(out_ch),
    .out_data(out_data), .round_done(round_done), .busy(busy), .overrun(overrun)
  );
  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      acc_m[i] = '0;
      ftw_m[i] = '0;
    end
  endtask
  task automatic check_idle_zero(input string tag);
    checks++;
    if ({lut_phase, out_valid, out_ch, out_data, round_done, busy, overrun, cfg_ready} !== '0) begin
      errors++;
      $display("FAIL %s: outputs phase=%h v=%b ch=%0d d=%h rd=%b busy=%b ovr=%b rdy=%b, required all 0",
               tag, lut_phase, out_valid, out_ch, out_data, round_done, busy, overrun, cfg_ready);
    end
  endtask
  task automatic cfg_write(input logic [1:0] ch, input logic [13:0] data);
    int n = 0;
    while (cfg_ready !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (cfg_ready !== 1'b1) begin
      errors++;
      $display("FAIL cfg_wait: cfg_ready=%b, required 1 within 20 cycles", cfg_ready);
    end
    cfg_valid = 1'b1; cfg_ch = ch; cfg_data = data;
    @(posedge clk); #1;
    cfg_valid = 1'b0;
    ftw_m[ch] = data;
  endtask
  task automatic run_round(input logic [3:0] en, input bit dbl, input bit midcfg, input bit wr);
    int chs[$];
    logic [13:0] ph[$];
    int k;
    logic [1:0] wch = 2'($urandom_range(0, 3));
    logic [13:0] wd = 14'($urandom);
    logic [1:0] mch = 2'($urandom_range(0, 3));
    logic [13:0] md = 14'($urandom);
    bit ev;
    if (wr) ftw_m[wch] = wd;
    for (int i = 0; i < 4; i++) if (en[i]) begin
      chs.push_back(i);
      ph.push_back(acc_m[i]);
      acc_m[i] = acc_m[i] + ftw_m[i];
    end
    k = chs.size();
    @(negedge clk);
    ch_en = en; sample_tick = 1'b1;
    if (wr) begin cfg_valid = 1'b1; cfg_ch = wch; cfg_data = wd; end
    @(posedge clk); #1;
    if (!dbl) sample_tick = 1'b0;
    cfg_valid = 1'b0;
    ch_en = 4'($urandom);
    for (int e = 1; e <= k + 3; e++) begin
      @(posedge clk); #1;
      sample_tick = 1'b0;
      if (midcfg && e == 2) begin cfg_valid = 1'b1; cfg_ch = mch; cfg_data = md; end
      ev = (e >= 2 && e <= k + 1);
      checks++;
      if (out_valid !== ev) begin
        errors++;
        $display("FAIL out_valid e=%0d: got %b, required %b", e, out_valid, ev);
      end
      if (ev) begin
        checks++;
        if (out_ch !== 2'(chs[e-2]) || out_data !== sine_f(ph[e-2])) begin
          errors++;
          $display("FAIL sample e=%0d: ch=%0d data=%h, required ch=%0d data=%h",
                   e, out_ch, out_data, chs[e-2], sine_f(ph[e-2]));
        end
      end
      if (e <= k) begin
        checks++;
        if (lut_phase !== ph[e-1]) begin
          errors++;
          $display("FAIL lut_phase e=%0d: got %h, required %h", e, lut_phase, ph[e-1]);
        end
      end
      checks++;
      if (round_done !== (e == k + 2) || busy !== (e <= k + 2) || cfg_ready !== (e == k + 3)) begin
        errors++;
        $display("FAIL status e=%0d k=%0d: rd=%b busy=%b rdy=%b, required rd=%b busy=%b rdy=%b",
                 e, k, round_done, busy, cfg_ready, e == k + 2, e <= k + 2, e == k + 3);
      end
    end
    if (midcfg) begin
      @(posedge clk); #1;
      cfg_valid = 1'b0;
      ftw_m[mch] = md;
    end
  endtask
  task automatic test_reset();
    model_reset();
    #12;
    check_idle_zero("reset_hold");
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (cfg_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL post_reset: rdy=%b busy=%b, required 1 0", cfg_ready, busy);
    end
  endtask
  task automatic test_single();
    cfg_write(2'd0, 14'h0100);
    repeat (3) begin
      run_round(4'b0001, 0, 0, 0);
      repeat (6) @(posedge clk);
      #1;
    end
  endtask
  task automatic test_all_channels();
    cfg_write(2'd0, 14'h0010);
    cfg_write(2'd1, 14'h0020);
    cfg_write(2'd2, 14'h0030);
    cfg_write(2'd3, 14'h0040);
    run_round(4'b1111, 0, 0, 0);
    run_round(4'b1111, 0, 0, 0);
  endtask
  task automatic test_sparse();
    run_round(4'b1010, 0, 0, 0);
    run_round(4'b1111, 0, 0, 0);
  endtask
  task automatic test_empty();
    run_round(4'b0000, 0, 0, 0);
  endtask
  task automatic test_overrun();
    checks++;
    if (overrun !== 1'b0) begin
      errors++;
      $display("FAIL overrun_pre: got %b, required 0", overrun);
    end
    run_round(4'b1111, 1, 1, 0);
    run_round(4'b1111, 0, 0, 0);
    checks++;
    if (overrun !== 1'b1) begin
      errors++;
      $display("FAIL overrun_sticky: got %b, required 1", overrun);
    end
  endtask
  task automatic test_mid_reset();
    @(negedge clk);
    ch_en = 4'b1111; sample_tick = 1'b1;
    @(posedge clk); #1;
    sample_tick = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    #1 check_idle_zero("mid_reset");
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    cfg_write(2'd0, 14'h0100);
    run_round(4'b0001, 0, 0, 0);
  endtask
  task automatic test_wrap();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    model_reset();
    @(posedge clk); #1;
    cfg_write(2'd0, 14'h3FFF);
    repeat (3) run_round(4'b0001, 0, 0, 0);
  endtask
  task automatic test_random();
    for (int r = 0; r < 30; r++) begin
      if ($urandom_range(0, 3) == 0) cfg_write(2'($urandom_range(0, 3)), 14'($urandom));
      run_round(4'($urandom), 0, 0, bit'($urandom_range(0, 1)));
    end
  endtask
  initial begin
    test_reset();
    test_single();
    test_all_channels();
    test_sparse();
    test_empty();
    test_random();
    test_overrun();
    test_mid_reset();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
